// File: rtl/m_register_file_sb.sv
// m_register_file_sb: register file with r0=0, post-reset clear sweep and busy scoreboard; define REGFILE_BYPASS_EN for write-to-read forwarding
module m_register_file_sb #(
  parameter int WORD_BITS = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] iDstAddr,
  input  logic [WORD_BITS-1:0] iDstVal,
  input  logic                 iDstValid,
  input  logic [ADDR_BITS-1:0] iRsvAddr,
  input  logic                 iRsvValid,
  input  logic [ADDR_BITS-1:0] iSrc0Addr,
  input  logic [ADDR_BITS-1:0] iSrc1Addr,
  output logic [WORD_BITS-1:0] oSrc0Val,
  output logic [WORD_BITS-1:0] oSrc1Val,
  output logic                 oSrc0Ready,
  output logic                 oSrc1Ready,
  output logic                 oReady
);
  localparam int NUM_REG = 2 ** ADDR_BITS;
  localparam logic [0:0] INIT = 1'b0, RUN = 1'b1;
  logic [0:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;
  logic [NUM_REG-1:0]   busy_q, busy_d;
  logic [WORD_BITS-1:0] mem_q [NUM_REG];
  logic [WORD_BITS-1:0] mem_d [NUM_REG];
  logic run, byp0, byp1;
  always_comb begin
    run = state_q == RUN;
`ifdef REGFILE_BYPASS_EN
    byp0 = run && iDstValid && iDstAddr == iSrc0Addr && |iSrc0Addr;
    byp1 = run && iDstValid && iDstAddr == iSrc1Addr && |iSrc1Addr;
`else
    byp0 = 1'b0;
    byp1 = 1'b0;
`endif
    oReady     = run;
    oSrc0Val   = byp0 ? iDstVal : (run && |iSrc0Addr) ? mem_q[iSrc0Addr] : '0;
    oSrc1Val   = byp1 ? iDstVal : (run && |iSrc1Addr) ? mem_q[iSrc1Addr] : '0;
    oSrc0Ready = run && (byp0 || !busy_q[iSrc0Addr]);
    oSrc1Ready = run && (byp1 || !busy_q[iSrc1Addr]);
  end
  // reserve is applied after writeback so a same-address reservation leaves busy set
  always_comb begin
    mem_d   = mem_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (!run) begin
      mem_d[cnt_q] = '0;
      cnt_d        = cnt_q + 1'b1;
      state_d      = &cnt_q ? RUN : INIT;
    end else begin
      if (iDstValid && |iDstAddr) begin
        mem_d[iDstAddr]  = iDstVal;
        busy_d[iDstAddr] = 1'b0;
      end
      if (iRsvValid && |iRsvAddr) busy_d[iRsvAddr] = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      mem_q   <= mem_d;
    end
  end
endmodule

// File: doc/m_register_file_sb.md
# m_register_file_sb

Parametrised successor to the CPU general-purpose register file. Adds a configurable word width and depth, an hardwired-zero register r0, and a sequential post-reset clear sweep. Adds a per-register busy scoreboard so the issue stage can detect read-after-write hazards. Sits between decode/issue (source reads, destination reservation) and writeback (destination write).

## Interface
Parameters:
- `WORD_BITS`, 32, data width of each register
- `ADDR_BITS`, 5, register address width; `NUM_REG = 2**ADDR_BITS`, depth ≥ 2

Ports:
- `clk` in 1: single clock; all state updates on posedge
- `rst` in 1: reset. Synchronous, active-high; one clock `clk` and synchronous active-high `rst`.
- `iDstAddr` in ADDR_BITS: writeback register address
- `iDstVal` in WORD_BITS: writeback data
- `iDstValid` in 1: writeback strobe; clears busy of `iDstAddr`
- `iRsvAddr` in ADDR_BITS: destination being reserved by issue
- `iRsvValid` in 1: reservation strobe; sets busy of `iRsvAddr`
- `iSrc0Addr`, `iSrc1Addr` in ADDR_BITS: read addresses
- `oSrc0Val`, `oSrc1Val` out WORD_BITS: read data (combinational)
- `oSrc0Ready`, `oSrc1Ready` out 1: source not busy (combinational)
- `oReady` out 1: clear sweep done; block accepts writes and reservations

## Operation
- States: INIT and RUN.
  - `rst` sampled high: state←INIT, sweep counter←0, all busy bits←0.
  - INIT, `rst` low: each edge writes 0 to `reg[cnt]` and increments `cnt`. On the edge that clears `reg[NUM_REG-1]`, state←RUN.
  - RUN stays in RUN until `rst`.
- INIT:
  - `iDstValid` and `iRsvValid` are ignored (dropped, not queued).
  - `oReady`=0, `oSrcXVal`=0, `oSrcXReady`=0.
- RUN writeback:
  - `iDstValid` and `iDstAddr`≠0: `reg[iDstAddr]`←`iDstVal` and `busy[iDstAddr]`←0.
- RUN reserve:
  - `iRsvValid` and `iRsvAddr`≠0: `busy[iRsvAddr]`←1.
- Simultaneous write and reserve to the same address: data is written and busy ends at 1 (the younger reservation wins).
- Write or reserve to a busy register is legal, with no error output. A write always clears busy unless a same-cycle reserve hits the same address.
- r0:
  - Never written and never busy.
  - Reads as 0 with Ready=1 in RUN.
  - Storage for r0 need not exist.
- Read ports are independent. Both may address the same register.
- `rst` mid-operation, in any state: restarts INIT with a full sweep and busy all cleared. Pending writes in that cycle are discarded.

## Timing
- Read latency is 0 cycles (combinational from address and registered state).
- Write latency: data is visible on read ports the cycle after the `iDstValid` edge (without bypass).
- Busy set by a reservation is visible (Ready=0) the cycle after the `iRsvValid` edge.
- After `rst` is deasserted, `oReady` rises after exactly NUM_REG edges (32 for the default).
- Reset values: `oReady`=0, `oSrc0Val`=`oSrc1Val`=0, `oSrc0Ready`=`oSrc1Ready`=0.
- No back-pressure. The caller must hold off writes and reservations until `oReady`=1.

## Configuration
- `REGFILE_BYPASS_EN` defined: write-to-read forwarding in RUN.
  - If `iDstValid`, `iDstAddr`==`iSrcXAddr`≠0: `oSrcXVal`=`iDstVal` in the same cycle.
  - `oSrcXReady`=1 in that same cycle, even if the register is busy.
  - A same-cycle reserve of that address does not affect the current-cycle Ready; it takes effect next cycle.
- `REGFILE_BYPASS_EN` undefined: reads return stored state only. The written value and cleared busy appear the following cycle.

## Test plan
- Reset sweep:
  - Stimulus: preload all registers with 0xA5A5A5A5, pulse `rst` 1 cycle, and assert `iDstValid` during INIT.
  - Required: `oReady`=0 for 32 cycles, then 1. Every register reads 0. The INIT write is lost.
- Basic write/read:
  - Stimulus: write r5=0x12345678, then read r5 on Src0 and r0 on Src1 the next cycle.
  - Required: Src0=0x12345678 with Ready=1. Src1=0 with Ready=1.
- Scoreboard:
  - Stimulus: reserve r7, then after 3 idle cycles write r7=0xDEAD0007.
  - Required: `oSrc0Ready`=0 for the 3 idle cycles, and 1 after the write (same cycle if bypass is enabled, next cycle otherwise).
- Collision:
  - Stimulus: same-cycle write r9=0x99 and reserve r9.
  - Required: next cycle r9 reads 0x99 with Ready=0.
- Bypass:
  - Stimulus: write r3=0xCAFEF00D while `iSrc1Addr`=3.
  - Required: with `REGFILE_BYPASS_EN`, Src1=0xCAFEF00D the same cycle. Without it, Src1 shows the old value, then 0xCAFEF00D next cycle.
- Reset mid-operation:
  - Stimulus: reserve r4, write r4=0x44, then assert `rst` for 1 cycle.
  - Required: `oReady` drops, a full 32-cycle sweep runs, then r4 reads 0 with Ready=1.
